// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: XLEN, divider op codes and divider FSM states.
// Helpers classify div ops as signed and/or remainder-producing.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    FIXUP,
    DONE
  } div_state_e;

  function automatic logic div_is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic div_is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Divider request/result bundle between the pipeline and div_ctrl.
// master = issuing pipeline side, slave = divider side.
interface div_ctrl_if;
  import riscv_pkg::*;

  logic            req_v;
  logic            req_ready;
  div_op_e         req_op;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            done_v;
  logic [4:0]      done_rd;
  logic [XLEN-1:0] done_data;

  modport master (
    output req_v, req_op, req_rd,
    output rs1_data, rs2_data, flush,
    input  req_ready, stall,
    input  done_v, done_rd, done_data
  );

  modport slave (
    input  req_v, req_op, req_rd,
    input  rs1_data, rs2_data, flush,
    output req_ready, stall,
    output done_v, done_rd, done_data
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: 33-bit trial subtract of the divisor
// from {rem, dividend msb}, quotient bit select and next remainder.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            msb,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] diff;
  logic            borrow;

  // rem[XLEN-1] set means the 33-bit partial exceeds any 32-bit divisor,
  // and the low-word difference is then already the exact remainder.
  assign low = {rem[XLEN-2:0], msb};
  assign {borrow, diff} = {1'b0, low} - {1'b0, dvs};
  assign q_bit = rem[XLEN-1] | ~borrow;
  assign rem_nxt = q_bit ? diff : low;

endmodule

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, 35-cycle latency.
// Build option DIV_SPECIAL_BYPASS_EN: div-by-zero/overflow skip to DONE.
module div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  div_ctrl_if.slave bus
);
  import riscv_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q;
  div_state_e state_d;

  div_op_e          op_q;
  logic [4:0]       rd_q;
  logic             sgn_q;
  logic             s1_q;
  logic             s2_q;
  logic             dbz_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  res_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  hold_data_q;
  logic [4:0]       hold_rd_q;

  logic            accept;
  logic            bypass;
  logic [XLEN-1:0] rem_nxt;
  logic            q_bit;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

`ifdef DIV_SPECIAL_BYPASS_EN
  logic            dbz_req;
  logic            ovf_req;
  logic [XLEN-1:0] byp_res;

  assign dbz_req = bus.rs2_data == '0;
  assign ovf_req = div_is_signed(bus.req_op)
                 & (bus.rs1_data == MIN_INT)
                 & (&bus.rs2_data);
  assign bypass = dbz_req | ovf_req;

  always_comb begin
    byp_res = '0;
    if (dbz_req)
      byp_res = div_is_rem(bus.req_op) ? bus.rs1_data : '1;
    else
      byp_res = div_is_rem(bus.req_op) ? '0 : MIN_INT;
  end
`else
  assign bypass = 1'b0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .msb     (quo_q[XLEN-1]),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.done_v    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = ~bus.flush;
        accept = bus.req_v & ~bus.flush;
        if (accept) state_d = bypass ? DONE : SETUP;
      end
      SETUP: state_d = RUN;
      RUN: if (cnt_q == LAST) state_d = FIXUP;
      FIXUP: state_d = DONE;
      DONE: begin
        bus.done_v = ~bus.flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
    bus.stall = (state_q != IDLE) | accept;
  end

  assign q_fix = (sgn_q & (s1_q ^ s2_q) & ~dbz_q)
               ? -quo_q : quo_q;
  assign r_fix = (sgn_q & s1_q) ? -rem_q : rem_q;

  // The dividend register shifts left and collects quotient bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= DIV;
      rd_q        <= '0;
      sgn_q       <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      dbz_q       <= 1'b0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_rd_q   <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_op;
        rd_q  <= bus.req_rd;
        sgn_q <= div_is_signed(bus.req_op);
        s1_q  <= bus.rs1_data[XLEN-1];
        s2_q  <= bus.rs2_data[XLEN-1];
        dbz_q <= bus.rs2_data == '0;
        quo_q <= bus.rs1_data;
        dvs_q <= bus.rs2_data;
`ifdef DIV_SPECIAL_BYPASS_EN
        if (bypass) res_q <= byp_res;
`endif
      end
      unique case (state_q)
        SETUP: begin
          if (sgn_q && s1_q) quo_q <= -quo_q;
          if (sgn_q && s2_q) dvs_q <= -dvs_q;
          rem_q <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          quo_q <= {quo_q[XLEN-2:0], q_bit};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
        FIXUP: res_q <= div_is_rem(op_q) ? r_fix : q_fix;
        default: ;
      endcase
      if (bus.done_v) begin
        hold_data_q <= res_q;
        hold_rd_q   <= rd_q;
      end
    end
  end

  assign bus.done_data = bus.done_v ? res_q : hold_data_q;
  assign bus.done_rd   = bus.done_v ? rd_q : hold_rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: results, latency, flush, reset, busy-ignore.
// Define DIV_SPECIAL_BYPASS_EN here too when the RTL is built with it.
module tb_div_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 35;
`endif

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input div_op_e op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_v = 1'b1;
    bus.req_op = op;
    bus.req_rd = rd;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(posedge clk);
    #1 bus.req_v = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 999;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done_v === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input div_op_e op,
                        input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, rd, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rd"}, 32'(bus.done_rd), 32'(rd));
    chk({tag, "_data"}, bus.done_data, exp);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done_v === 1'b1) cnt++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    bus.req_v = 1'b0;
    bus.req_op = DIV;
    bus.req_rd = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.flush = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_done_v", 32'(bus.done_v), 32'd0);
    chk("rst_done_rd", 32'(bus.done_rd), 32'd0);
    chk("rst_done_data", bus.done_data, 32'd0);
    reset = 1'b0;

    run_op("div_100_7", DIV, 5'd5, 32'd100, 32'd7, 32'd14, 35);
    @(negedge clk);
    chk("hold_v", 32'(bus.done_v), 32'd0);
    chk("hold_data", bus.done_data, 32'd14);
    chk("hold_rd", 32'(bus.done_rd), 32'd5);

    run_op("rem_100_7", REM, 5'd6, 32'd100, 32'd7, 32'd2, 35);
    run_op("rem_m7_2", REM, 5'd1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 35);
    run_op("div_m7_2", DIV, 5'd2, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 35);
    run_op("divu_max_2", DIVU, 5'd3, 32'hFFFF_FFFF, 32'd2,
           32'h7FFF_FFFF, 35);
    run_op("remu_big", REMU, 5'd4, 32'hFFFF_FFFF, 32'h8000_0000,
           32'h7FFF_FFFF, 35);
    run_op("divu_5_0", DIVU, 5'd7, 32'd5, 32'd0,
           32'hFFFF_FFFF, SPEC_LAT);
    run_op("rem_m5_0", REM, 5'd8, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, SPEC_LAT);
    run_op("div_m5_0", DIV, 5'd9, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFF, SPEC_LAT);
    run_op("div_ovf", DIV, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, SPEC_LAT);
    run_op("rem_ovf", REM, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, SPEC_LAT);

    // flush during the 10th RUN cycle
    issue(DIV, 5'd12, 32'd1000, 32'd10);
    repeat (11) @(negedge clk);
    chk("pre_flush_stall", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(bus.req_ready), 32'd1);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    count_done(40, cnt);
    chk("flush_no_done", 32'(cnt), 32'd0);
    run_op("div_9_3", DIV, 5'd13, 32'd9, 32'd3, 32'd3, 35);

    // requests while busy must be ignored
    issue(DIV, 5'd14, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.req_v = 1'b1;
    bus.req_op = DIVU;
    bus.req_rd = 5'd20;
    bus.rs1_data = 32'd1;
    bus.rs2_data = 32'd1;
    #1 chk("busy_ready", 32'(bus.req_ready), 32'd0);
    repeat (5) @(negedge clk);
    bus.req_v = 1'b0;
    lat = 999;
    for (int i = 10; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done_v === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("busy_lat", 32'(lat), 32'd35);
    chk("busy_rd", 32'(bus.done_rd), 32'd14);
    chk("busy_data", bus.done_data, 32'd14);
    count_done(40, cnt);
    chk("busy_no_extra", 32'(cnt), 32'd0);

    // reset mid-RUN
    issue(DIVU, 5'd15, 32'd77, 32'd3);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_done_v", 32'(bus.done_v), 32'd0);
    chk("mid_rst_rd", 32'(bus.done_rd), 32'd0);
    chk("mid_rst_data", bus.done_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_done(40, cnt);
    chk("mid_rst_no_done", 32'(cnt), 32'd0);
    run_op("divu_50_5", DIVU, 5'd16, 32'd50, 32'd5, 32'd10, 35);

    // flush and req_v together in IDLE
    @(negedge clk);
    bus.req_v = 1'b1;
    bus.req_op = DIV;
    bus.req_rd = 5'd17;
    bus.rs1_data = 32'd8;
    bus.rs2_data = 32'd2;
    bus.flush = 1'b1;
    #1 chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.req_v = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_req_stall", 32'(bus.stall), 32'd0);
    count_done(40, cnt);
    chk("flush_req_no_done", 32'(cnt), 32'd0);

    // flush in DONE suppresses the strobe
    issue(DIV, 5'd18, 32'd21, 32'd4);
    repeat (34) @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("done_flush_v", 32'(bus.done_v), 32'd0);
    chk("done_flush_data", bus.done_data, 32'd10);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    count_done(40, cnt);
    chk("done_flush_none", 32'(cnt), 32'd0);
    chk("done_flush_hold", bus.done_data, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter CNT_W, default 5, iteration counter width; must satisfy 2**CNT_W == XLEN.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_v  input  1  divide request valid.
REQ-006 req_ready  output  1  high only in IDLE; a request is accepted when req_v & req_ready.
REQ-007 req_op  input  2  0 DIV, 1 DIVU, 2 REM, 3 REMU.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 rs1_data  input  XLEN  dividend.
REQ-010 rs2_data  input  XLEN  divisor.
REQ-011 flush  input  1  kill the in-flight operation.
REQ-012 stall  output  1  pipeline stall: (state != IDLE) | (req_v & req_ready).
REQ-013 done_v  output  1  one-cycle result strobe.
REQ-014 done_rd  output  5  tag of the completing operation, valid with done_v.
REQ-015 done_data  output  XLEN  result, valid with done_v.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, RUN, FIXUP, DONE.
REQ-017 On accept, IDLE->SETUP; latch op, rd, rs1, rs2, signed flag (ops 0/2), dividend sign, divisor sign, divisor==0.
REQ-018 SETUP (1 cycle): for signed ops, replace operands by magnitudes as 33-bit values (0x80000000 -> +2^31); unsigned ops zero-extend; clear quotient and partial remainder; counter <= 0; ->RUN.
REQ-019 RUN: one restoring step per cycle: trial = {rem[31:0], dividend msb} - divisor (33-bit); if trial >= 0, rem <= trial and shift 1 into quotient, else shift in 0; counter++; ->FIXUP after the step with counter == XLEN-1 (exactly 32 RUN cycles).
REQ-020 FIXUP (1 cycle): negate quotient iff signed & (sign1 ^ sign2) & ~div_by_zero; negate remainder iff signed & sign1; select quotient (ops 0/1) or remainder (ops 2/3) into the result register; ->DONE.
REQ-021 DONE (1 cycle): done_v = 1, done_rd and done_data from registers; ->IDLE.
REQ-022 Normal latency: done_v asserts exactly 35 cycles after the accept cycle; throughput one operation per 36 cycles.
REQ-023 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder = dividend, for signed and unsigned ops.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quotient 0x80000000 and remainder 0.
REQ-025 req_v while not IDLE SHALL be ignored; operands are not re-sampled.
REQ-026 flush in any non-IDLE state SHALL force IDLE on the next edge with no done_v; flush in DONE suppresses that cycle's done_v combinationally.
REQ-027 flush and req_v in the same IDLE cycle: flush wins, request is not accepted.
REQ-028 done_data and done_rd SHALL hold their last value when done_v is low.

Reset
REQ-029 reset SHALL force IDLE, counter 0, done_v 0, done_rd 0, done_data 0, stall 0, req_ready 1, from any state including mid-RUN.

Configuration
REQ-030 Macro DIV_SPECIAL_BYPASS_EN: when defined, accepted divide-by-zero and signed-overflow requests go IDLE->DONE directly with the REQ-023/024 result (done_v 1 cycle after accept); when undefined, these cases take the full 35-cycle path and the same results come from the normal datapath.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the div_op_e enum (DIV, DIVU, REM, REMU), the div_state_e enum, and the XLEN constant.
REQ-032 One sub-module div_step: combinational 33-bit trial subtract and quotient-bit select; div_ctrl owns all registers and the FSM.

Verification
REQ-033 DIV 100 / 7, rd=5 -> done_v 35 cycles later, done_rd=5, done_data=14; REM same operands -> 2.
REQ-034 REM -7 / 2 -> 0xFFFFFFFF (-1); DIV -7 / 2 -> 0xFFFFFFFD (-3); DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF; REM -5 / 0 -> 0xFFFFFFFB; latency 1 with DIV_SPECIAL_BYPASS_EN, 35 without.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-037 flush at RUN cycle 10 -> no done_v ever, req_ready=1 next cycle, new DIV 9/3 accepted and returns 3.
REQ-038 reset asserted mid-RUN -> outputs at reset values immediately; req_v ignored during a busy op leaves the result unchanged.
